// File: rtl/eth_rx_parser.sv
// Ethernet receive framing stage: strips preamble/SFD, filters on destination MAC,
// captures source MAC and EtherType, checks length and FCS, forwards payload minus FCS.
module eth_rx_parser #(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter int unsigned MAX_LEN   = 1518,
  parameter int unsigned MIN_LEN   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_active,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic [7:0]  stream_o,
  output logic        stb,
  output logic        last,
  output logic [15:0] type_o,
  output logic [47:0] mac_o,
  output logic        frame_ok,
  output logic        frame_err
);

  // state  | meaning
  // IDLE   | waiting for a rising edge of rx_active
  // PRE    | counting 0x55 preamble bytes, expecting 0xD5
  // DST    | comparing destination MAC against station and broadcast
  // SRC    | shifting in source MAC
  // TYPE   | capturing EtherType, then publishing mac_o/type_o
  // PAY    | payload + FCS through the 5-entry delay line
  // DROP   | discarding until the envelope ends
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DST, S_SRC, S_TYPE, S_PAY, S_DROP
  } state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MAX_LEN_W   = 11'(MAX_LEN);
  localparam logic [10:0] MIN_LEN_W   = 11'(MIN_LEN);

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  state_t          state_q, state_d;
  logic            act_prev_q, act_prev_d;
  logic [2:0]      pre_cnt_q, pre_cnt_d;
  logic [2:0]      fld_cnt_q, fld_cnt_d;
  logic [47:0]     dst_exp_q, dst_exp_d;
  logic            dst_loc_q, dst_loc_d;
  logic            dst_bc_q, dst_bc_d;
  logic [47:0]     src_sh_q, src_sh_d;
  logic [7:0]      type_hi_q, type_hi_d;
  logic [47:0]     mac_q, mac_d;
  logic [15:0]     type_q, type_d;
  logic [10:0]     len_q, len_d;
  logic [31:0]     crc_q, crc_d;
  logic [4:0][7:0] dl_q, dl_d;
  logic [2:0]      pay_cnt_q, pay_cnt_d;
  logic            err_pend_q, err_pend_d;
  logic [7:0]      stream_q, stream_d;
  logic            stb_q, stb_d;
  logic            last_q, last_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;

  logic [31:0]     crc_nxt;
  logic [10:0]     len_nxt;
  logic            loc_hit;
  logic            bc_hit;

  always_comb begin
    state_d    = state_q;
    act_prev_d = rx_active;
    pre_cnt_d  = pre_cnt_q;
    fld_cnt_d  = fld_cnt_q;
    dst_exp_d  = dst_exp_q;
    dst_loc_d  = dst_loc_q;
    dst_bc_d   = dst_bc_q;
    src_sh_d   = src_sh_q;
    type_hi_d  = type_hi_q;
    mac_d      = mac_q;
    type_d     = type_q;
    len_d      = len_q;
    crc_d      = crc_q;
    dl_d       = dl_q;
    pay_cnt_d  = pay_cnt_q;
    err_pend_d = err_pend_q;
    stream_d   = stream_q;
    stb_d      = 1'b0;
    last_d     = 1'b0;
    ok_d       = 1'b0;
    err_d      = 1'b0;

    crc_nxt = crc_step(crc_q, rx_byte);
    len_nxt = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
    loc_hit = dst_loc_q && (rx_byte == dst_exp_q[47:40]);
    bc_hit  = dst_bc_q && (rx_byte == 8'hFF);

    case (state_q)
      S_IDLE: begin
        // The byte on the rising edge counts as the first preamble byte.
        if (rx_active && !act_prev_q) begin
          state_d    = S_PRE;
          pre_cnt_d  = 3'd0;
          err_pend_d = 1'b0;
          if (rx_dv) begin
            if (rx_byte == 8'h55) pre_cnt_d = 3'd1;
            else                  state_d   = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!rx_active) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (rx_dv) begin
          if (rx_byte == 8'h55 && pre_cnt_q < 3'd7) begin
            pre_cnt_d = pre_cnt_q + 3'd1;
          end else if (rx_byte == 8'hD5 && pre_cnt_q != 3'd0) begin
            state_d   = S_DST;
            crc_d     = '1;
            len_d     = '0;
            fld_cnt_d = '0;
            dst_exp_d = LOCAL_MAC;
            dst_loc_d = 1'b1;
            dst_bc_d  = 1'b1;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_DST: begin
        if (!rx_active) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (rx_dv) begin
          crc_d     = crc_nxt;
          len_d     = len_nxt;
          dst_exp_d = {dst_exp_q[39:0], 8'h00};
          dst_loc_d = loc_hit;
          dst_bc_d  = bc_hit;
          if (fld_cnt_q == 3'd5) begin
            fld_cnt_d = '0;
            state_d   = (loc_hit || bc_hit) ? S_SRC : S_DROP;
          end else begin
            fld_cnt_d = fld_cnt_q + 3'd1;
          end
        end
      end
      S_SRC: begin
        if (!rx_active) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (rx_dv) begin
          crc_d    = crc_nxt;
          len_d    = len_nxt;
          src_sh_d = {src_sh_q[39:0], rx_byte};
          if (fld_cnt_q == 3'd5) begin
            fld_cnt_d = '0;
            state_d   = S_TYPE;
          end else begin
            fld_cnt_d = fld_cnt_q + 3'd1;
          end
        end
      end
      S_TYPE: begin
        if (!rx_active) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (rx_dv) begin
          crc_d = crc_nxt;
          len_d = len_nxt;
          if (fld_cnt_q == 3'd0) begin
            type_hi_d = rx_byte;
            fld_cnt_d = 3'd1;
          end else begin
            mac_d     = src_sh_q;
            type_d    = {type_hi_q, rx_byte};
            fld_cnt_d = '0;
            pay_cnt_d = '0;
            state_d   = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (!rx_active) begin
          state_d   = S_IDLE;
          pay_cnt_d = '0;
          // Oldest entry is the final payload byte; the newer four are the FCS.
          if (len_q >= MIN_LEN_W && crc_q == CRC_RESIDUE && pay_cnt_q == 3'd5) begin
            stream_d = dl_q[4];
            stb_d    = 1'b1;
            last_d   = 1'b1;
            ok_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (rx_dv) begin
          if (len_nxt > MAX_LEN_W) begin
            state_d    = S_DROP;
            err_pend_d = 1'b1;
            pay_cnt_d  = '0;
          end else begin
            crc_d = crc_nxt;
            len_d = len_nxt;
            dl_d  = {dl_q[3:0], rx_byte};
            if (pay_cnt_q == 3'd5) begin
              stream_d = dl_q[4];
              stb_d    = 1'b1;
            end else begin
              pay_cnt_d = pay_cnt_q + 3'd1;
            end
          end
        end
      end
      S_DROP: begin
        if (!rx_active) begin
          err_d      = err_pend_q;
          err_pend_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Previous-sample register resets high so a frame already in flight is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      act_prev_q <= 1'b1;
      pre_cnt_q  <= '0;
      fld_cnt_q  <= '0;
      dst_exp_q  <= '0;
      dst_loc_q  <= 1'b0;
      dst_bc_q   <= 1'b0;
      src_sh_q   <= '0;
      type_hi_q  <= '0;
      mac_q      <= '0;
      type_q     <= '0;
      len_q      <= '0;
      crc_q      <= '1;
      dl_q       <= '0;
      pay_cnt_q  <= '0;
      err_pend_q <= 1'b0;
      stream_q   <= '0;
      stb_q      <= 1'b0;
      last_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_prev_q <= act_prev_d;
      pre_cnt_q  <= pre_cnt_d;
      fld_cnt_q  <= fld_cnt_d;
      dst_exp_q  <= dst_exp_d;
      dst_loc_q  <= dst_loc_d;
      dst_bc_q   <= dst_bc_d;
      src_sh_q   <= src_sh_d;
      type_hi_q  <= type_hi_d;
      mac_q      <= mac_d;
      type_q     <= type_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      dl_q       <= dl_d;
      pay_cnt_q  <= pay_cnt_d;
      err_pend_q <= err_pend_d;
      stream_q   <= stream_d;
      stb_q      <= stb_d;
      last_q     <= last_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  assign stream_o  = stream_q;
  assign stb       = stb_q;
  assign last      = last_q;
  assign type_o    = type_q;
  assign mac_o     = mac_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_eth_rx_parser.sv
// Directed bench for eth_rx_parser: expected payload bytes and end pulses are queued
// as frames are built and checked as the DUT emits them.
module tb_eth_rx_parser;
  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  typedef struct packed {
    logic [7:0] b;
    logic       l;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rx_active;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic [7:0]  stream_o;
  logic        stb;
  logic        last;
  logic [15:0] type_o;
  logic [47:0] mac_o;
  logic        frame_ok;
  logic        frame_err;

  eth_rx_parser dut (
    .clk(clk), .rst(rst), .rx_active(rx_active), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .stream_o(stream_o), .stb(stb), .last(last), .type_o(type_o), .mac_o(mac_o),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] pay[$];
  logic [7:0] frm[$];
  exp_t       exp_q[$];
  logic [1:0] evt_q[$];   // {frame_ok, frame_err}
  exp_t       e_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_calc();
    logic [31:0] c;
    c = '1;
    foreach (frm[i]) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic fill_pay(input int n, input logic [7:0] base);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(base + 8'(i));
  endtask

  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(src[8*i +: 8]);
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    foreach (pay[i]) frm.push_back(pay[i]);
    fcs = ~crc_calc();
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
  endtask

  task automatic expect_pay(input int n, input bit fin);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b = pay[i];
      e.l = fin && (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit allow_gap);
    if (allow_gap && $urandom_range(0, 4) == 0) begin
      @(negedge clk);
      rx_active = 1'b1;
      rx_dv     = 1'b0;
    end
    @(negedge clk);
    rx_active = 1'b1;
    rx_dv     = 1'b1;
    rx_byte   = b;
  endtask

  task automatic drive(input int npre, input int gap);
    for (int i = 0; i < npre; i++) send(8'h55, i != 0);
    send(8'hD5, 1'b1);
    foreach (frm[i]) send(frm[i], 1'b1);
    @(negedge clk);
    rx_active = 1'b0;
    rx_dv     = 1'b0;
    rx_byte   = 8'h00;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    repeat (6) @(negedge clk);
    chk({tag, "_stb_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_pulse_left"}, 64'(evt_q.size()), 64'd0);
    exp_q.delete();
    evt_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stb"}, 64'(stb), 64'd0);
    chk({tag, "_last"}, 64'(last), 64'd0);
    chk({tag, "_ok"}, 64'(frame_ok), 64'd0);
    chk({tag, "_err"}, 64'(frame_err), 64'd0);
    chk({tag, "_stream"}, 64'(stream_o), 64'd0);
    chk({tag, "_mac"}, 64'(mac_o), 64'd0);
    chk({tag, "_type"}, 64'(type_o), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (stb) begin
        if (exp_q.size() == 0) chk("stb_unexpected", 64'(stb), 64'd0);
        else begin
          e_m = exp_q.pop_front();
          chk("stream_o", 64'(stream_o), 64'(e_m.b));
          chk("last", 64'(last), 64'(e_m.l));
        end
      end else if (last) begin
        chk("last_without_stb", 64'(last), 64'd0);
      end
      if (frame_ok || frame_err) begin
        if (evt_q.size() == 0) chk("pulse_unexpected", 64'({frame_ok, frame_err}), 64'd0);
        else chk("pulse", 64'({frame_ok, frame_err}), 64'(evt_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    rx_active = 1'b0;
    rx_dv     = 1'b0;
    rx_byte   = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Good minimum-length unicast frame
    fill_pay(46, 8'h00);
    build(LOCAL, 48'h00_11_22_33_44_55, 16'h0800);
    expect_pay(46, 1'b1);
    evt_q.push_back(2'b10);
    drive(7, 4);
    settle("good");
    chk("good_mac", 64'(mac_o), 64'h0000_0011_2233_4455);
    chk("good_type", 64'(type_o), 64'h0800);

    // Single payload bit flipped after FCS computed
    fill_pay(46, 8'h00);
    build(LOCAL, 48'h00_11_22_33_44_55, 16'h0800);
    frm[14 + 10] = frm[14 + 10] ^ 8'h04;
    pay[10]      = pay[10] ^ 8'h04;
    expect_pay(45, 1'b0);
    evt_q.push_back(2'b01);
    drive(7, 4);
    settle("badcrc");

    // Filtered destination: silent, shadow registers hold
    fill_pay(46, 8'h10);
    build(48'h0A_0B_0C_0D_0E_0F, 48'h66_77_88_99_AA_BB, 16'h86DD);
    drive(7, 4);
    settle("filtered");
    chk("filtered_mac", 64'(mac_o), 64'h0000_0011_2233_4455);
    chk("filtered_type", 64'(type_o), 64'h0800);

    // Broadcast, 1600 bytes: overrun at byte 1519, one error at envelope end
    fill_pay(1582, 8'h00);
    build(BCAST, 48'h66_77_88_99_AA_BB, 16'h86DD);
    expect_pay(1499, 1'b0);
    evt_q.push_back(2'b01);
    drive(7, 4);
    settle("long");
    chk("long_mac", 64'(mac_o), 64'h0000_6677_8899_AABB);
    chk("long_type", 64'(type_o), 64'h86DD);

    // Runt with valid FCS
    fill_pay(22, 8'h50);
    build(LOCAL, 48'h00_11_22_33_44_55, 16'h0800);
    expect_pay(21, 1'b0);
    evt_q.push_back(2'b01);
    drive(7, 4);
    settle("runt");

    // Back-to-back, one idle cycle; second frame has a single preamble byte
    fill_pay(46, 8'h40);
    build(LOCAL, 48'h10_20_30_40_50_60, 16'h0806);
    expect_pay(46, 1'b1);
    evt_q.push_back(2'b10);
    drive(7, 1);
    fill_pay(60, 8'h80);
    build(BCAST, 48'hA1_A2_A3_A4_A5_A6, 16'h88CC);
    expect_pay(60, 1'b1);
    evt_q.push_back(2'b10);
    drive(1, 4);
    settle("b2b");
    chk("b2b_mac", 64'(mac_o), 64'h0000_A1A2_A3A4_A5A6);
    chk("b2b_type", 64'(type_o), 64'h88CC);

    // Reset while payload byte 20 is on the bus; frame tail must be ignored
    fill_pay(46, 8'hA0);
    build(LOCAL, 48'h0C_0D_0E_0F_10_11, 16'h88B5);
    expect_pay(14, 1'b0);
    for (int i = 0; i < 7; i++) send(8'h55, i != 0);
    send(8'hD5, 1'b1);
    for (int i = 0; i < 14 + 19; i++) send(frm[i], 1'b1);
    send(frm[14 + 19], 1'b1);
    #2 rst = 1'b0;
    #1 check_zero("midreset");
    chk("midreset_queue", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 14 + 20; i < frm.size(); i++) send(frm[i], 1'b1);
    @(negedge clk);
    rx_active = 1'b0;
    rx_dv     = 1'b0;
    repeat (3) @(negedge clk);
    settle("aborted");
    chk("aborted_mac", 64'(mac_o), 64'd0);

    fill_pay(46, 8'h30);
    build(LOCAL, 48'h00_11_22_33_44_55, 16'h0800);
    expect_pay(46, 1'b1);
    evt_q.push_back(2'b10);
    drive(7, 4);
    settle("after_reset");
    chk("after_reset_mac", 64'(mac_o), 64'h0000_0011_2233_4455);
    chk("after_reset_type", 64'(type_o), 64'h0800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
